// File: rtl/ysyx_22040729_id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, operand selection and
// load-use bubble insertion in front of the execute-stage ALU.
module ysyx_22040729_id_ex_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_AW     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,

    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [DATA_WIDTH-1:0] id_pc,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic                  id_src1_pc,
    input  logic                  id_src2_imm,
    input  logic [REG_AW-1:0]     id_rd,
    input  logic                  id_rd_wen,
    input  logic                  id_is_load,
    input  logic [2:0]            id_func3,
    input  logic [6:0]            id_func7,
    input  logic [1:0]            id_model,
    input  logic                  id_len_dw,

    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic [DATA_WIDTH-1:0] ex_src1,
    output logic [DATA_WIDTH-1:0] ex_src2,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic [2:0]            ex_func3,
    output logic [6:0]            ex_func7,
    output logic [1:0]            ex_model,
    output logic                  ex_len_dw,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [REG_AW-1:0]     ex_rd,
    output logic                  ex_rd_wen,
    output logic                  ex_is_load,
    input  logic [DATA_WIDTH-1:0] ex_result,

    input  logic                  mem_valid,
    input  logic [REG_AW-1:0]     mem_rd,
    input  logic                  mem_rd_wen,
    input  logic [DATA_WIDTH-1:0] mem_result
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic                  rs1_ex_hit, rs1_mem_hit, rs2_ex_hit, rs2_mem_hit;
    logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;
    logic                  ex_can_fwd, ex_load_pending, hazard;
    logic                  slot_free, capture;

    assign ex_valid = (state == FULL);

    // A load in EX has no result yet, so it is never a forwarding source.
    assign ex_can_fwd  = ex_valid && ex_rd_wen && !ex_is_load;
    assign rs1_ex_hit  = ex_can_fwd && (ex_rd == id_rs1) && (id_rs1 != '0);
    assign rs2_ex_hit  = ex_can_fwd && (ex_rd == id_rs2) && (id_rs2 != '0);
    assign rs1_mem_hit = mem_valid && mem_rd_wen && (mem_rd == id_rs1) && (id_rs1 != '0);
    assign rs2_mem_hit = mem_valid && mem_rd_wen && (mem_rd == id_rs2) && (id_rs2 != '0);

    always_comb begin
        fwd_rs1 = id_rs1_data;
        if (rs1_ex_hit)       fwd_rs1 = ex_result;
        else if (rs1_mem_hit) fwd_rs1 = mem_result;
    end

    always_comb begin
        fwd_rs2 = id_rs2_data;
        if (rs2_ex_hit)       fwd_rs2 = ex_result;
        else if (rs2_mem_hit) fwd_rs2 = mem_result;
    end

    // rs2 is always checked because store data needs it even with an immediate src2.
    assign ex_load_pending = ex_valid && ex_is_load && ex_rd_wen && (ex_rd != '0);
    assign hazard = ex_load_pending &&
                    ((!id_src1_pc && (ex_rd == id_rs1)) || (ex_rd == id_rs2));

    assign slot_free = !ex_valid || ex_ready;
    assign id_ready  = slot_free && !hazard && !flush;
    assign capture   = id_valid && id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush)          state_nxt = EMPTY;
        else if (capture)   state_nxt = FULL;
        else if (slot_free) state_nxt = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_src1       <= '0;
            ex_src2       <= '0;
            ex_store_data <= '0;
            ex_func3      <= '0;
            ex_func7      <= '0;
            ex_model      <= '0;
            ex_len_dw     <= 1'b0;
            ex_pc         <= '0;
            ex_rd         <= '0;
            ex_rd_wen     <= 1'b0;
            ex_is_load    <= 1'b0;
        end else if (capture) begin
            ex_src1       <= id_src1_pc  ? id_pc  : fwd_rs1;
            ex_src2       <= id_src2_imm ? id_imm : fwd_rs2;
            ex_store_data <= fwd_rs2;
            ex_func3      <= id_func3;
            ex_func7      <= id_func7;
            ex_model      <= id_model;
            ex_len_dw     <= id_len_dw;
            ex_pc         <= id_pc;
            ex_rd         <= id_rd;
            ex_rd_wen     <= id_rd_wen;
            ex_is_load    <= id_is_load;
        end
    end

endmodule

// File: doc/ysyx_22040729_id_ex_stage.md
# ysyx_22040729_id_ex_stage

ID/EX pipeline stage that sits directly upstream of the execute-stage ALU. It captures decoded instructions from ID with a valid/ready handshake and resolves register-operand forwarding from the EX and MEM stages. It selects ALU operands (register, PC or immediate), detects load-use hazards and inserts bubbles, then presents registered operands and ALU control (`src1`, `src2`, `alu_func3`, `alu_func7`, `alu_model`, `alu_len_dw`) to EX.

## Interface
Parameters:
- `DATA_WIDTH`, 64: operand/result width.
- `REG_AW`, 5: register-index width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  kill captured/incoming instruction (branch redirect).
- `id_valid`  in  1  ID holds an instruction.
- `id_ready`  out  1  stage accepts an instruction this cycle.
- `id_pc`  in  DATA_WIDTH  instruction PC.
- `id_rs1`, `id_rs2`  in  REG_AW  source register indices.
- `id_rs1_data`, `id_rs2_data`  in  DATA_WIDTH  regfile read data.
- `id_imm`  in  DATA_WIDTH  sign-extended immediate.
- `id_src1_pc`  in  1  src1 = PC instead of rs1.
- `id_src2_imm`  in  1  src2 = imm instead of rs2.
- `id_rd`  in  REG_AW  destination index.
- `id_rd_wen`  in  1  writes rd.
- `id_is_load`  in  1  instruction is a load.
- `id_func3`  in  3, `id_func7`  in  7, `id_model`  in  2, `id_len_dw`  in  1  ALU control.
- `ex_ready`  in  1  EX accepts the held instruction.
- `ex_valid`  out  1  held instruction valid.
- `ex_src1`, `ex_src2`  out  DATA_WIDTH  ALU operands.
- `ex_store_data`  out  DATA_WIDTH  forwarded rs2 value.
- `ex_func3` 3, `ex_func7` 7, `ex_model` 2, `ex_len_dw` 1  out  ALU control.
- `ex_pc`  out  DATA_WIDTH, `ex_rd`  out  REG_AW, `ex_rd_wen`  out  1, `ex_is_load`  out  1  sideband.
- `ex_result`  in  DATA_WIDTH  ALU result of the instruction currently held (`ex_*`).
- `mem_valid`  in  1, `mem_rd`  in  REG_AW, `mem_rd_wen`  in  1, `mem_result`  in  DATA_WIDTH  MEM-stage writeback source.

## Operation
- Reset (async, `rst_n`=0): `ex_valid`=0 and every registered output = 0.
- Forward rs1 and rs2 independently. Priority order:
  - EX hit: `ex_valid && ex_rd_wen && !ex_is_load && ex_rd==rsX && rsX!=0` → `ex_result`.
  - MEM hit: `mem_valid && mem_rd_wen && mem_rd==rsX && rsX!=0` → `mem_result`.
  - Otherwise → `id_rsX_data`.
- Index 0 is never forwarded.
- Load-use hazard: `ex_valid && ex_is_load && ex_rd_wen && ex_rd!=0`, and `ex_rd` matches `id_rs1` (when `!id_src1_pc`) or `id_rs2` (always checked, since store data needs it).
- Operand select:
  - `src1 = id_src1_pc ? id_pc : fwd_rs1`.
  - `src2 = id_src2_imm ? id_imm : fwd_rs2`.
  - `ex_store_data = fwd_rs2`.
- `slot_free = !ex_valid || ex_ready`.
- `id_ready = slot_free && !hazard && !flush`.
- Next-state priority per clock:
  1. `flush`: `ex_valid`←0.
  2. `id_valid && id_ready`: capture all fields, `ex_valid`←1.
  3. `slot_free` but no capture (hazard, or no `id_valid`): `ex_valid`←0 (bubble).
  4. Else hold all outputs unchanged.
- Payload registers may load on any capture; when `ex_valid`=0 they are don't-care except at reset (0).
- The two states are EMPTY (`ex_valid`=0) and FULL (`ex_valid`=1).
  - EMPTY→FULL on capture.
  - FULL→FULL on capture with `ex_ready`.
  - FULL→EMPTY on `ex_ready` without capture, or on `flush`.
  - FULL holds while `!ex_ready`.
- Outputs never change while FULL and `!ex_ready` (except on flush/reset).

## Timing
- Latency 1 cycle: an instruction accepted at edge N is visible on `ex_*` after edge N.
- All `ex_*` outputs are registered. `id_ready` and the hazard signal are combinational from current-cycle inputs and state.
- A load-use stall lasts exactly 1 cycle when `ex_ready`=1: a bubble is inserted, then the load is in MEM and its data is forwarded via `mem_result`.
- Back-to-back dependent ALU ops forward with zero stall through `ex_result`.
- Flush asserted with a simultaneous `id_valid`: the instruction is not captured and `id_ready`=0.
- Reset mid-operation discards the held instruction immediately (asynchronous).

## Test plan
- Reset then idle: `rst_n`=0→1 → `ex_valid`=0, `ex_src1`=`ex_src2`=0, `id_ready`=1.
- Back-to-back dependency: `addi x5,x0,7`, then `add x6,x5,x5` with stale `id_rs1_data`=0 and `ex_result`=7 → second capture gives `ex_src1`=`ex_src2`=7, no stall.
- Load-use: `ld x8` held in EX, then `add x9,x8,x1` → `id_ready`=0 for 1 cycle and a bubble (`ex_valid`=0). Next cycle with `mem_result`=0x1234 → `ex_src1`=0x1234.
- x0 guard: `ex_rd`=0, `ex_rd_wen`=1, `ex_result`=0xFF; ID reads x0 → `ex_src1` = `id_rs1_data` (0).
- Backpressure: FULL, `ex_ready`=0 for 3 cycles while `id_valid`=1 → `id_ready`=0 and outputs stable; when `ex_ready`=1 the new instruction is captured next edge.
- Flush: FULL and `flush`=1 with `id_valid`=1 → next cycle `ex_valid`=0, ID instruction not consumed.
